// File: rtl/wrap_sequencer.sv
// ============================================================================
// wrap_sequencer : command-driven controller around an N-bit up/down counter
// Revision 1.0   : initial release
// ============================================================================
`default_nettype none

module wrap_sequencer #(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [N-1:0] cmd_start,
   input  logic         cmd_dir,
   input  logic [W-1:0] cmd_wraps,
   input  logic         abort,
   output logic         cnt_load,
   output logic         cnt_up_down,
   output logic [N-1:0] cnt_input_load,
   input  logic [N-1:0] cnt_value,
   input  logic         cnt_carry,
   output logic         busy,
   output logic         done,
   output logic         aborted,
   output logic [W-1:0] wrap_count,
   output logic [N-1:0] final_value
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [N-1:0] C_ONE = N'(1);

   state_t         state_q, state_d;
   logic [N-1:0]   start_q, start_d;
   logic           dir_q, dir_d;
   logic [W-1:0]   wraps_q, wraps_d;
   logic [W-1:0]   wrap_count_q, wrap_count_d;
   logic           aborted_q, aborted_d;
   logic [N-1:0]   final_q, final_d;
   logic           cmd_ready_q, cmd_ready_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           cnt_load_q, cnt_load_d;
   logic [N-1:0]   cnt_in_q, cnt_in_d;
   logic [W-1:0]   wrap_inc;
   logic [N-1:0]   landing;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         start_q      <= '0;
         dir_q        <= 1'b1;
         wraps_q      <= '0;
         wrap_count_q <= '0;
         aborted_q    <= 1'b0;
         final_q      <= '0;
         cmd_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         cnt_load_q   <= 1'b1;
         cnt_in_q     <= '0;
      end else begin
         state_q      <= state_d;
         start_q      <= start_d;
         dir_q        <= dir_d;
         wraps_q      <= wraps_d;
         wrap_count_q <= wrap_count_d;
         aborted_q    <= aborted_d;
         final_q      <= final_d;
         cmd_ready_q  <= cmd_ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         cnt_load_q   <= cnt_load_d;
         cnt_in_q     <= cnt_in_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      start_d      = start_q;
      dir_d        = dir_q;
      wraps_d      = wraps_q;
      wrap_count_d = wrap_count_q;
      aborted_d    = aborted_q;
      final_d      = final_q;
      wrap_inc     = (wrap_count_q == '1) ? wrap_count_q : wrap_count_q + W'(1);
      landing      = dir_q ? cnt_value + C_ONE : cnt_value - C_ONE;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               start_d      = cmd_start;
               dir_d        = cmd_dir;
               wraps_d      = cmd_wraps;
               wrap_count_d = '0;
               aborted_d    = 1'b0;
               state_d      = S_LOAD;
            end
         end
         S_LOAD: begin
            if (wraps_q == '0) begin
               state_d = S_DONE;
               final_d = start_q;
            end else if (abort) begin
               state_d   = S_DONE;
               aborted_d = 1'b1;
               final_d   = start_q;
            end else begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (cnt_carry) begin
               wrap_count_d = wrap_inc;
               if (wrap_inc == wraps_q) begin
                  state_d = S_DONE;
                  final_d = dir_q ? '0 : '1;
               end
            end
            // a terminating carry on the same edge takes precedence over abort
            if (abort && (state_d == S_RUN)) begin
               state_d   = S_DONE;
               aborted_d = 1'b1;
               final_d   = landing;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      cmd_ready_d = (state_d == S_IDLE);
      busy_d      = (state_d == S_LOAD) || (state_d == S_RUN);
      done_d      = (state_d == S_DONE);
      cnt_load_d  = (state_d != S_RUN);
      cnt_in_d    = (state_d == S_LOAD) ? start_d : final_d;
   end

   assign cmd_ready      = cmd_ready_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign aborted        = aborted_q;
   assign wrap_count     = wrap_count_q;
   assign final_value    = final_q;
   assign cnt_load       = cnt_load_q;
   assign cnt_up_down    = dir_q;
   assign cnt_input_load = cnt_in_q;

endmodule

`default_nettype wire

// File: tb/tb_wrap_sequencer.sv
// ============================================================================
// tb_wrap_sequencer : bench for wrap_sequencer with a behavioural counter stage
// Revision 1.0      : initial release
// ============================================================================
`default_nettype none

module tb_wrap_sequencer;

   localparam int N = 4;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [N-1:0] cmd_start;
   logic         cmd_dir;
   logic [W-1:0] cmd_wraps;
   logic         abort;
   logic         cnt_load;
   logic         cnt_up_down;
   logic [N-1:0] cnt_input_load;
   logic [N-1:0] cnt_value;
   logic         cnt_carry;
   logic         busy;
   logic         done;
   logic         aborted;
   logic [W-1:0] wrap_count;
   logic [N-1:0] final_value;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   wrap_sequencer #(.N(N), .W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_start(cmd_start), .cmd_dir(cmd_dir), .cmd_wraps(cmd_wraps),
      .abort(abort),
      .cnt_load(cnt_load), .cnt_up_down(cnt_up_down), .cnt_input_load(cnt_input_load),
      .cnt_value(cnt_value), .cnt_carry(cnt_carry),
      .busy(busy), .done(done), .aborted(aborted),
      .wrap_count(wrap_count), .final_value(final_value)
   );

   // The counter stage the sequencer is wrapped around
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        cnt_value <= '0;
      else if (cnt_load) cnt_value <= cnt_input_load;
      else if (cnt_up_down) cnt_value <= cnt_value + 4'd1;
      else               cnt_value <= cnt_value - 4'd1;
   end
   assign cnt_carry = cnt_up_down ? (cnt_value == 4'hF) : (cnt_value == 4'h0);

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Expected outcome of one run, cycle 0 = accept cycle; ka = abort cycle (0 = none)
   function automatic void model(input int st, input int dir, input int wr, input int ka,
                                 output int dk, output int fin, output int wc, output int ab);
      int s, k1, kt;
      s  = dir ? 1 : -1;
      k1 = 2 + (dir ? 15 - st : st);
      kt = k1 + 16 * (wr - 1);
      if (wr == 0) begin
         dk = 2; fin = st; wc = 0; ab = 0;
      end else if (ka == 1) begin
         dk = 2; fin = st; wc = 0; ab = 1;
      end else if (ka >= 2 && ka < kt) begin
         dk  = ka + 1;
         fin = (((st + s * (ka - 1)) % 16) + 16) % 16;
         wc  = (ka >= k1) ? (ka - k1) / 16 + 1 : 0;
         ab  = 1;
      end else begin
         dk = kt + 1; fin = dir ? 0 : 15; wc = wr; ab = 0;
      end
   endfunction

   task automatic run(input string tag, input int st, input int dir, input int wr, input int ka,
                      input int edk, input int efin, input int ewc, input int eab);
      int dk, guard, pulses;
      guard = 0;
      while (!cmd_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check({tag, " ready"}, int'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd_start = N'(st);
      cmd_dir   = dir[0];
      cmd_wraps = W'(wr);
      abort     = 1'b0;
      dk = -1;
      pulses = 0;
      for (int k = 1; k <= 600 && dk < 0; k++) begin
         @(negedge clk);
         cmd_valid = 1'b0;
         abort     = (k == ka);
         if (done) begin
            dk = k;
            pulses++;
         end
      end
      if (dk < 0) begin
         check({tag, " done timeout"}, 0, 1);
      end else begin
         check({tag, " done cycle"}, dk, edk);
         check({tag, " final_value"}, int'(final_value), efin);
         check({tag, " wrap_count"}, int'(wrap_count), ewc);
         check({tag, " aborted"}, int'(aborted), eab);
         check({tag, " counter at done"}, int'(cnt_value), efin);
         @(negedge clk);
         abort = 1'b0;
         if (done) pulses++;
         check({tag, " single done pulse"}, pulses, 1);
         check({tag, " counter held"}, int'(cnt_value), efin);
         check({tag, " wrap_count held"}, int'(wrap_count), ewc);
         check({tag, " aborted held"}, int'(aborted), eab);
      end
      abort = 1'b0;
   endtask

   typedef struct {
      string name;
      int st, dir, wr, ka;
      int dk, fin, wc, ab;
   } vec_t;

   vec_t tbl[7];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dk, fin, wc, ab, st, dir, wr, ka;

      tbl[0] = '{"up run",         14, 1, 1, 0,  4,  0, 1, 0};
      tbl[1] = '{"down run",        1, 0, 2, 0, 20, 15, 2, 0};
      tbl[2] = '{"zero wraps",      9, 1, 0, 0,  2,  9, 0, 0};
      tbl[3] = '{"abort run",       3, 1, 5, 4,  5,  6, 0, 1};
      tbl[4] = '{"abort at carry", 14, 1, 1, 3,  4,  0, 1, 0};
      tbl[5] = '{"abort in load",   7, 0, 3, 1,  2,  7, 0, 1};
      tbl[6] = '{"abort after wrap", 2, 0, 3, 10, 11, 9, 1, 1};

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_start = '0; cmd_dir = 1'b0;
      cmd_wraps = '0; abort = 1'b0;
      repeat (2) @(negedge clk);
      check("reset cmd_ready", int'(cmd_ready), 1);
      check("reset cnt_load", int'(cnt_load), 1);
      check("reset cnt_input_load", int'(cnt_input_load), 0);
      check("reset cnt_up_down", int'(cnt_up_down), 1);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      check("reset final_value", int'(final_value), 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++)
         run(tbl[i].name, tbl[i].st, tbl[i].dir, tbl[i].wr, tbl[i].ka,
             tbl[i].dk, tbl[i].fin, tbl[i].wc, tbl[i].ab);

      // Cycle-exact trace of the up run
      @(negedge clk);
      cmd_valid = 1'b1; cmd_start = 4'd14; cmd_dir = 1'b1; cmd_wraps = 8'd1;
      @(negedge clk); cmd_valid = 1'b0;
      check("trace c1 cnt_load", int'(cnt_load), 1);
      check("trace c1 input_load", int'(cnt_input_load), 14);
      check("trace c1 busy", int'(busy), 1);
      check("trace c1 cmd_ready", int'(cmd_ready), 0);
      @(negedge clk);
      check("trace c2 cnt_load", int'(cnt_load), 0);
      check("trace c2 counter", int'(cnt_value), 14);
      @(negedge clk);
      check("trace c3 counter", int'(cnt_value), 15);
      check("trace c3 done", int'(done), 0);
      @(negedge clk);
      check("trace c4 done", int'(done), 1);
      check("trace c4 cnt_load", int'(cnt_load), 1);
      check("trace c4 cmd_ready", int'(cmd_ready), 0);
      check("trace c4 busy", int'(busy), 0);
      @(negedge clk);
      check("trace c5 cmd_ready", int'(cmd_ready), 1);

      // Handshake: valid held high through a run
      cmd_valid = 1'b1; cmd_start = 4'd14; cmd_dir = 1'b1; cmd_wraps = 8'd1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("hs ready low while busy", int'(cmd_ready), 0);
      end
      check("hs first done", int'(done), 1);
      @(negedge clk);
      check("hs idle cycle ready", int'(cmd_ready), 1);
      check("hs idle cycle busy", int'(busy), 0);
      cmd_start = 4'd9; cmd_wraps = 8'd0;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("hs second accepted", int'(busy), 1);
      check("hs second load value", int'(cnt_input_load), 9);
      @(negedge clk);
      check("hs second done", int'(done), 1);
      check("hs second final", int'(final_value), 9);

      // Reset in the middle of a run
      @(negedge clk);
      cmd_valid = 1'b1; cmd_start = 4'd0; cmd_dir = 1'b1; cmd_wraps = 8'd3;
      @(negedge clk); cmd_valid = 1'b0;
      repeat (20) @(negedge clk);
      check("midrun busy before reset", int'(busy), 1);
      check("midrun wraps before reset", int'(wrap_count), 1);
      rst_n = 1'b0;
      #1;
      check("midrun reset cmd_ready", int'(cmd_ready), 1);
      check("midrun reset cnt_load", int'(cnt_load), 1);
      check("midrun reset input_load", int'(cnt_input_load), 0);
      check("midrun reset busy", int'(busy), 0);
      check("midrun reset wrap_count", int'(wrap_count), 0);
      check("midrun reset done", int'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      begin
         int seen = 0;
         for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) seen++;
         end
         check("midrun no done after reset", seen, 0);
      end

      // Randomised runs against the arithmetic model
      for (int i = 0; i < 40; i++) begin
         st  = int'($urandom_range(0, 15));
         dir = int'($urandom_range(0, 1));
         wr  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3));
         ka  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 52));
         model(st, dir, wr, ka, dk, fin, wc, ab);
         run($sformatf("rand%0d s%0d d%0d w%0d a%0d", i, st, dir, wr, ka),
             st, dir, wr, ka, dk, fin, wc, ab);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/wrap_sequencer.md
Name: wrap_sequencer

Overview:
- Command-driven controller wrapped around the team's N-bit up/down counter (load/up_down/input_load in, count_out/carry_out back).
- Accepts a command {start value, direction, wrap target} over a valid/ready handshake and loads the counter.
- Counts the counter's wrap events, stops after the target number of wraps or on abort, then freezes the counter at its landing value.
- Acts as both feeder (drives load/direction) and consumer (monitors count_out and carry_out) of the counter stage.

Parameters:
- N, 4, counter width; must match the counter instance.
- W, 8, width of wrap target and wrap counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_start  input  N  counter start value.
- cmd_dir  input  1  1 = up, 0 = down; same polarity as counter up_down.
- cmd_wraps  input  W  number of wraps to run.
- abort  input  1  stop the current run.
- cnt_load  output  1  drives counter load.
- cnt_up_down  output  1  drives counter up_down.
- cnt_input_load  output  N  drives counter input_load.
- cnt_value  input  N  counter count_out.
- cnt_carry  input  1  counter carry_out; high in a cycle where the counter wraps at the next edge (15->0 up, 0->15 down for N=4).
- busy  output  1  high in LOAD and RUN.
- done  output  1  one-cycle completion pulse.
- aborted  output  1  valid with done; run ended by abort.
- wrap_count  output  W  wraps seen in the current/last run.
- final_value  output  N  counter value the run ended on.

Behaviour:
- Clock/reset: one clock, asynchronous active-low reset; all outputs registered.
- Reset values:
  - State IDLE; cmd_ready=1.
  - cnt_load=1, cnt_input_load=0, cnt_up_down=1.
  - busy=0, done=0, aborted=0, wrap_count=0, final_value=0.
- Reset mid-run: immediate return to the reset values; the run is lost, no done pulse.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - cmd_ready=1.
  - cnt_load=1 with cnt_input_load=hold register, which holds the counter frozen.
  - On cmd_valid && cmd_ready: capture start/dir/wraps, clear wrap_count and aborted, go to LOAD.
- LOAD (exactly 1 cycle):
  - cnt_load=1, cnt_input_load=start, cnt_up_down=dir, busy=1, cmd_ready=0.
  - cnt_carry is ignored.
  - If wraps==0: go to DONE with final_value=hold=start. Otherwise go to RUN.
- RUN:
  - cnt_load=0, cnt_up_down=dir, busy=1.
  - Each edge with cnt_carry=1: wrap_count+1.
  - When that increment reaches wraps: go to DONE, final_value=hold = dir ? 0 : 2^N-1 (the post-wrap value).
- Abort:
  - In RUN: go to DONE with aborted=1 and final_value=hold=(cnt_value ±1) mod 2^N, i.e. the value the counter lands on at that edge.
  - In LOAD: go to DONE with aborted=1 and final_value=start.
  - In IDLE/DONE: ignored.
  - Abort on the same edge as the terminating carry: completion wins, aborted=0, and wrap_count is incremented.
- DONE (1 cycle):
  - done=1, cnt_load=1, cnt_input_load=hold.
  - Then go to IDLE.
  - cmd_ready=0 in DONE.
- Output persistence: wrap_count, final_value and aborted hold until the next command accept.
- Arithmetic: wrap_count saturates at 2^W-1 (unreachable in normal use); counter arithmetic is mod 2^N.
- Timing: command accepted in cycle 0 -> LOAD in cycle 1 -> counter shows start in cycle 2.

Test Plan:
- Reset: assert rst_n=0 mid-RUN -> cmd_ready=1, cnt_load=1, cnt_input_load=0, busy=0, wrap_count=0 immediately; no done pulse.
- Up run: N=4, start=14, dir=1, wraps=1, accepted in cycle 0 -> cnt_load=1 only in cycle 1; counter 14, 15 in cycles 2-3; done=1 in cycle 4 with final_value=0, wrap_count=1, aborted=0; counter then holds 0.
- Down run: start=1, dir=0, wraps=2 -> carry in cycles 3 and 19; done in cycle 20 with final_value=15, wrap_count=2.
- Zero wraps: start=9, wraps=0 -> LOAD in cycle 1, done in cycle 2, final_value=9, wrap_count=0; counter held at 9.
- Abort: start=3, dir=1, wraps=5, abort in cycle 4 (counter=5) -> done in cycle 5, aborted=1, final_value=6, wrap_count=0, counter held at 6.
- Handshake: cmd_valid held high through a run -> second command accepted only in the IDLE cycle after done; abort coincident with the terminating carry -> aborted=0, wrap_count=target.
